// File: rtl/instr_sequencer.sv
// ============================================================================
// Module  : instr_sequencer
// Purpose : Loadable program memory that issues one instruction at a time to a
//           processor and advances on the processor's completion pulse.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_sequencer #(
    parameter int              IW        = 10,
    parameter int              AW        = 4,
    parameter logic [IW-1:0]   HALT_WORD = {IW{1'b1}}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [IW-1:0] load_data,
    input  logic          run,
    input  logic          done,
    output logic [IW-1:0] instruction,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic          halted
);

    localparam int c_DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_pc_adv;
    logic          w_fetch_halt;
    logic [IW-1:0] r_mem [c_DEPTH];
    logic [IW-1:0] r_instr;
    logic [AW-1:0] r_pc;
    logic          r_valid;
    logic          r_halted;

    assign w_fetch_halt = (r_mem[r_pc] == HALT_WORD);

    always_comb begin
        w_next   = r_state;
        w_pc_adv = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_next = w_fetch_halt ? S_HALT : S_ISSUE;
            end
            S_ISSUE: begin
                // Completion may arrive in the same cycle the instruction is offered.
                if (done) begin
                    w_next   = S_FETCH;
                    w_pc_adv = 1'b1;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done) begin
                    w_next   = S_FETCH;
                    w_pc_adv = 1'b1;
                end
            end
            S_HALT: begin
                if (!run) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_instr  <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_valid  <= (w_next == S_ISSUE);
            r_halted <= (w_next == S_HALT);
            if (w_pc_adv) begin
                r_pc <= r_pc + 1'b1;
            end
            if (r_state == S_FETCH) begin
                r_instr <= r_mem[r_pc];
            end
        end
    end

    // Program storage has no reset; writes only land while idle and out of reset.
    always_ff @(posedge clk) begin
        if (rst && (r_state == S_IDLE) && load_en) begin
            r_mem[load_addr] <= load_data;
        end
    end

    assign instruction = r_instr;
    assign instr_valid = r_valid;
    assign pc          = r_pc;
    assign halted      = r_halted;

endmodule

`default_nettype wire
